// File: rtl/fetch_if.sv
// fetch_if: handshake/bus bundle between the fetch stage and its surroundings.
interface fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr_pc;
    logic [31:0] instr_in;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic        misalign_err;
    modport master (
        input  stall, redirect, redirect_pc, halt, instr_in,
        output instr_pc, id_instr, id_pc4, id_valid, halted, fetch_count, misalign_err
    );
    modport slave (
        output stall, redirect, redirect_pc, halt, instr_in,
        input  instr_pc, id_instr, id_pc4, id_valid, halted, fetch_count, misalign_err
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID register, halt FSM and fetch statistics.
// Define DELAY_SLOT_EN to keep the instruction after a taken branch (delay slot) instead of flushing it.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, id_instr_q, id_instr_d, id_pc4_q, id_pc4_d, fetch_count_q, fetch_count_d;
    logic        id_valid_q, id_valid_d, misalign_q, misalign_d, cap;
    logic [31:0] pc4;
    assign pc4 = pc_q + 32'd4;
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        misalign_d = misalign_q;
        cap        = 1'b0;
        if (state_q == HALTED || bus.halt) begin
            state_d    = HALTED;
            id_instr_d = 32'd0;
            id_valid_d = 1'b0;
        end else if (bus.redirect) begin
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            misalign_d = misalign_q | (|bus.redirect_pc[1:0]);
`ifdef DELAY_SLOT_EN
            id_instr_d = bus.instr_in;
            id_pc4_d   = pc4;
            id_valid_d = 1'b1;
            cap        = 1'b1;
`else
            id_instr_d = 32'd0;
            id_valid_d = 1'b0;
`endif
        end else if (!bus.stall) begin
            pc_d       = pc4;
            id_instr_d = bus.instr_in;
            id_pc4_d   = pc4;
            id_valid_d = 1'b1;
            cap        = 1'b1;
        end
        fetch_count_d = (cap && fetch_count_q != 32'hFFFF_FFFF) ? fetch_count_q + 32'd1 : fetch_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            id_instr_q    <= 32'd0;
            id_pc4_q      <= 32'd0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end
    assign bus.instr_pc     = pc_q;
    assign bus.id_instr     = id_instr_q;
    assign bus.id_pc4       = id_pc4_q;
    assign bus.id_valid     = id_valid_q;
    assign bus.halted       = state_q == HALTED;
    assign bus.fetch_count  = fetch_count_q;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage (two instances with different RESET_PC).
module tb_fetch_stage;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    typedef struct {
        string       tag;
        logic [31:0] pc, ins, pc4, cnt;
        logic        v, h, mis;
    } exp_t;

    logic clk = 1'b0, rst_a, rst_b;
    int   errors = 0, checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    fetch_if a ();
    fetch_if b ();

    function automatic logic [31:0] mem(input logic [31:0] addr);
        case (addr)
            32'h100: mem = 32'h11;
            32'h104: mem = 32'h22;
            32'h108: mem = 32'h33;
            default: mem = addr ^ 32'hA500_0000;
        endcase
    endfunction

    assign a.instr_in = mem(a.instr_pc);
    assign b.instr_in = mem(b.instr_pc);

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut_a (.clk(clk), .rst(rst_a), .bus(a));
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst(rst_b), .bus(b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] pc, ins, pc4, input logic v, h,
                                input logic [31:0] cnt, input logic mis);
        mk.tag = tag; mk.pc = pc; mk.ins = ins; mk.pc4 = pc4;
        mk.v = v; mk.h = h; mk.cnt = cnt; mk.mis = mis;
    endfunction

    task automatic step(input logic r, s, rd, input logic [31:0] rp, input logic h, input exp_t e);
        exp_t x;
        rst_a = r; a.stall = s; a.redirect = rd; a.redirect_pc = rp; a.halt = h;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", e.tag);
        end else begin
            x = q.pop_front();
            chk({x.tag, ".instr_pc"}, a.instr_pc, x.pc);
            chk({x.tag, ".id_instr"}, a.id_instr, x.ins);
            chk({x.tag, ".id_pc4"}, a.id_pc4, x.pc4);
            chk({x.tag, ".id_valid"}, {31'd0, a.id_valid}, {31'd0, x.v});
            chk({x.tag, ".halted"}, {31'd0, a.halted}, {31'd0, x.h});
            chk({x.tag, ".fetch_count"}, a.fetch_count, x.cnt);
            chk({x.tag, ".misalign_err"}, {31'd0, a.misalign_err}, {31'd0, x.mis});
        end
    endtask

    initial begin
        rst_b = 1'b1; b.stall = 1'b0; b.redirect = 1'b0; b.redirect_pc = 32'd0; b.halt = 1'b0;
        step(1, 0, 0, 0, 0, mk("reset", 32'h100, 0, 0, 0, 0, 0, 0));
        chk("b_reset.instr_pc", b.instr_pc, 32'hFFFF_FFFC);
        rst_b = 1'b0;
        step(0, 0, 0, 0, 0, mk("fetch1", 32'h104, 32'h11, 32'h104, 1, 0, 1, 0));
        chk("b_wrap.instr_pc", b.instr_pc, 32'h0);
        chk("b_wrap.id_pc4", b.id_pc4, 32'h0);
        chk("b_wrap.id_instr", b.id_instr, 32'h5AFF_FFFC);
        chk("b_wrap.fetch_count", b.fetch_count, 32'd1);
        step(0, 0, 0, 0, 0, mk("fetch2", 32'h108, 32'h22, 32'h108, 1, 0, 2, 0));
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, mk("stall", 32'h108, 32'h22, 32'h108, 1, 0, 2, 0));
        step(0, 0, 0, 0, 0, mk("resume", 32'h10C, 32'h33, 32'h10C, 1, 0, 3, 0));
        step(1, 0, 0, 0, 0, mk("reset2", 32'h100, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk("pre_redir", 32'h104, 32'h11, 32'h104, 1, 0, 1, 0));
        step(0, 1, 1, 32'h200, 0, DS ? mk("redir_stall", 32'h200, 32'h22, 32'h108, 1, 0, 2, 0)
                                     : mk("redir_stall", 32'h200, 32'h0, 32'h104, 0, 0, 1, 0));
        step(0, 0, 0, 0, 0, mk("target", 32'h204, 32'hA500_0200, 32'h204, 1, 0, DS ? 3 : 2, 0));
        step(0, 0, 1, 32'h203, 0, DS ? mk("misalign", 32'h200, 32'hA500_0204, 32'h208, 1, 0, 4, 1)
                                     : mk("misalign", 32'h200, 32'h0, 32'h204, 0, 0, 2, 1));
        step(0, 0, 0, 0, 0, mk("sticky", 32'h204, 32'hA500_0200, 32'h204, 1, 0, DS ? 5 : 3, 1));
        step(0, 1, 1, 32'h300, 1, mk("halt_redir", 32'h204, 32'h0, 32'h204, 0, 1, DS ? 5 : 3, 1));
        step(0, 0, 1, 32'h400, 0, mk("halted_redir", 32'h204, 32'h0, 32'h204, 0, 1, DS ? 5 : 3, 1));
        step(0, 0, 0, 0, 0, mk("halted_idle", 32'h204, 32'h0, 32'h204, 0, 1, DS ? 5 : 3, 1));
        step(1, 0, 0, 0, 0, mk("reset3", 32'h100, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk("run_again", 32'h104, 32'h11, 32'h104, 1, 0, 1, 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
